// File: rtl/imm_ext_pkg.sv
// -----------------------------------------------------------------------------
// imm_ext_pkg
// Shared types for the immediate-extender pipeline stage.
//   imm_mode_e  : extension mode carried alongside each immediate
//                 (SIGN, ZERO, UPPER for LUI placement, BOFS for branch offsets).
//   occ_state_e : occupancy of the two-entry output buffer. This is also the
//                 FSM state of imm_ext_pipe.
// No ports; the other files bring it in with import imm_ext_pkg::*.
// -----------------------------------------------------------------------------
package imm_ext_pkg;

  typedef enum logic [1:0] {
    MODE_SIGN  = 2'b00,
    MODE_ZERO  = 2'b01,
    MODE_UPPER = 2'b10,
    MODE_BOFS  = 2'b11
  } imm_mode_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } occ_state_e;

  localparam int CNT_W = 32;

endpackage

// File: rtl/imm_ext_if.sv
// -----------------------------------------------------------------------------
// imm_ext_if
// Bundles the input and output handshakes of the immediate-extender stage.
//   in_valid/in_ready/in_imm/in_mode : decode -> stage
//   out_valid/out_ready/out_data     : stage -> execute
// Modports:
//   slave  : the pipeline stage (consumes the in channel, produces the out channel)
//   master : the surrounding logic, i.e. the producer plus the consumer
//
// Handshake rules, the same on both channels: a transfer happens on a rising
// clk edge where valid and ready are both 1. Once valid is raised it stays
// high, and the payload stays unchanged, until that transfer. ready may change
// in any cycle and does not depend combinationally on valid.
// -----------------------------------------------------------------------------
interface imm_ext_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_imm;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;

  modport slave (
    input  in_valid, in_imm, in_mode, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_imm, in_mode, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/imm_ext_func.sv
// -----------------------------------------------------------------------------
// imm_ext_func
// Purely combinational immediate extender.
//   imm  [IN_W]  : raw immediate field
//   mode [2]     : imm_mode_e encoding
//   ext  [OUT_W] : extended result
// SIGN  : sign-extend to OUT_W.
// ZERO  : zero-extend to OUT_W.
// UPPER : imm in the top IN_W bits, zeros below. The concatenation is exactly
//         OUT_W wide, so the result is always the top OUT_W bits.
// BOFS  : SIGN result shifted left by 2. The two MSBs shifted out are dropped.
// -----------------------------------------------------------------------------
module imm_ext_func
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  imm,
  input  logic [1:0]       mode,
  output logic [OUT_W-1:0] ext
);

  logic [OUT_W-1:0] sign_ext;
  logic [OUT_W-1:0] zero_ext;
  logic [OUT_W-1:0] upper_ext;

  assign sign_ext  = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
  assign zero_ext  = {{(OUT_W-IN_W){1'b0}}, imm};
  assign upper_ext = {imm, {(OUT_W-IN_W){1'b0}}};

  always_comb begin
    ext = sign_ext;
    case (imm_mode_e'(mode))
      MODE_SIGN:  ext = sign_ext;
      MODE_ZERO:  ext = zero_ext;
      MODE_UPPER: ext = upper_ext;
      MODE_BOFS:  ext = sign_ext << 2;
      default:    ext = sign_ext;
    endcase
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// -----------------------------------------------------------------------------
// imm_ext_pipe
// One registered pipeline stage that extends the decode immediate for the ALU
// B-mux and the branch adder. A two-entry skid buffer (main_q and skid_q) lets
// in_ready come straight from a flop while still sustaining one transfer per
// cycle under back-pressure.
// Ports:
//   clk       : single clock, rising edge
//   rst_n     : synchronous, active-low reset
//   bus       : imm_ext_if.slave (in_valid/in_ready/in_imm/in_mode,
//               out_valid/out_ready/out_data)
//   xfer_cnt  : 32-bit count of output transfers, wraps; only present when
//               IMM_EXT_CNT_EN is defined
//   dbg_state : current buffer occupancy (FSM state)
// Optional feature macro: IMM_EXT_CNT_EN.
// Parameters: IN_W (immediate width), OUT_W (result width, must be >= IN_W+2).
// -----------------------------------------------------------------------------
module imm_ext_pipe
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  imm_ext_if.slave         bus,
`ifdef IMM_EXT_CNT_EN
  output logic [CNT_W-1:0] xfer_cnt,
`endif
  output occ_state_e       dbg_state
);

  // BOFS needs two bits of headroom above the sign-extended immediate.
  generate
    if (OUT_W < IN_W + 2) begin : g_bad_width
      $error("imm_ext_pipe: OUT_W must be at least IN_W+2");
    end
  endgenerate

  occ_state_e       state_q;
  logic             in_ready_q;
  logic [OUT_W-1:0] main_q;
  logic [OUT_W-1:0] skid_q;
  logic [OUT_W-1:0] ext;
  logic             out_valid;
  logic             in_fire;
  logic             out_fire;

  // The immediate is extended on the way in, so both buffer entries hold
  // final results and in_mode only matters in the cycle of an input transfer.
  imm_ext_func #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_func (
    .imm  (bus.in_imm),
    .mode (bus.in_mode),
    .ext  (ext)
  );

  assign out_valid     = (state_q != ST_EMPTY);
  assign in_fire       = bus.in_valid & in_ready_q;
  assign out_fire      = out_valid & bus.out_ready;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = main_q;
  assign dbg_state     = state_q;

  // in_ready_q always gets the ready value implied by the state being entered,
  // so it is 0 exactly while the buffer is FULL. After reset it comes back
  // from EMPTY on the first edge with rst_n high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          in_ready_q <= 1'b1;
          if (in_fire) begin
            main_q  <= ext;
            state_q <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_q     <= ext;
            in_ready_q <= 1'b1;
          end else if (in_fire) begin
            // The consumer stalled, so the new entry waits behind main_q.
            skid_q     <= ext;
            state_q    <= ST_FULL;
            in_ready_q <= 1'b0;
          end else if (out_fire) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            main_q     <= skid_q;
            state_q    <= ST_ONE;
            in_ready_q <= 1'b1;
          end else begin
            in_ready_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= ST_EMPTY;
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef IMM_EXT_CNT_EN
  // Wraps naturally from all-ones to zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      xfer_cnt <= '0;
    end else if (out_fire) begin
      xfer_cnt <= xfer_cnt + 32'd1;
    end
  end
`endif

endmodule
